// File: rtl/inst_rom_loader_pkg.sv
// inst_rom_loader_pkg: shared bus types, constants and loader FSM encodings
//   InstBus / InstAddrBus : 32-bit instruction word and fetch address types
//   ZeroWord              : value returned on masked or invalid fetches
//   ChipEnable/ChipDisable: fetch chip-enable levels
//   ld_state_e            : LD_IDLE / LD_LOAD / LD_DONE (2-bit)
package inst_rom_loader_pkg;
    typedef logic [31:0] InstBus;
    typedef logic [31:0] InstAddrBus;
    localparam InstBus ZeroWord    = 32'h0000_0000;
    localparam logic   ChipEnable  = 1'b1;
    localparam logic   ChipDisable = 1'b0;
    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_e;
endpackage

// File: rtl/inst_rom_loader_if.sv
// inst_rom_loader_if: fetch and byte-load signal bundle of the instruction ROM loader
//   fetch : ce, addr (in) / inst, addr_err (out)
//   load  : ld_start, ld_valid, ld_byte, ld_last (in) / ld_ready, ld_done, ld_words, ld_ovf (out)
//   cpu   : cpu_hold (out)
//   slave modport = loader side, master modport = CPU/host side
interface inst_rom_loader_if #(parameter int DEPTH_LOG2 = 10);
    import inst_rom_loader_pkg::*;
    logic                ce;
    InstAddrBus          addr;
    InstBus              inst;
    logic                addr_err;
    logic                ld_start;
    logic                ld_valid;
    logic                ld_ready;
    logic [7:0]          ld_byte;
    logic                ld_last;
    logic                ld_done;
    logic [DEPTH_LOG2:0] ld_words;
    logic                ld_ovf;
    logic                cpu_hold;
    modport slave (
        input  ce, addr, ld_start, ld_valid, ld_byte, ld_last,
        output inst, addr_err, ld_ready, ld_done, ld_words, ld_ovf, cpu_hold
    );
    modport master (
        output ce, addr, ld_start, ld_valid, ld_byte, ld_last,
        input  inst, addr_err, ld_ready, ld_done, ld_words, ld_ovf, cpu_hold
    );
endinterface

// File: rtl/inst_rom_loader_ld_word_pack.sv
// ld_word_pack: assembles a big-endian 32-bit word from a byte stream
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : drop any partial word (new session)
//   i_en           : a byte is consumed this cycle
//   i_byte, i_last : data byte and end-of-stream marker
//   o_word_valid   : o_word must be written on this edge
//   o_word         : assembled word, unfilled low bytes zero
module ld_word_pack
    import inst_rom_loader_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [7:0] i_byte,
    input  logic       i_last,
    output logic       o_word_valid,
    output InstBus     o_word
);
    logic [1:0] r_cnt;
    InstBus     r_acc;
    InstBus     w_shift;
    // ~r_cnt == 3 - r_cnt: byte 0 lands in [31:24], byte 3 in [7:0]
    assign w_shift      = {24'h0, i_byte} << {~r_cnt, 3'b000};
    assign o_word       = r_acc | w_shift;
    assign o_word_valid = i_en & (i_last | (&r_cnt));
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_acc <= ZeroWord;
        end else if (i_clr || o_word_valid) begin
            r_cnt <= '0;
            r_acc <= ZeroWord;
        end else if (i_en) begin
            r_cnt <= r_cnt + 2'd1;
            r_acc <= o_word;
        end
    end
endmodule

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: run-time loadable instruction memory answering CPU fetches
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : inst_rom_loader_if.slave (fetch port, byte-load port, cpu_hold)
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input logic               i_clk,
    input logic               i_rst_n,
    inst_rom_loader_if.slave  bus
);
    ld_state_e           r_state;
    ld_state_e           w_next;
    logic [DEPTH_LOG2:0] r_wptr;
    logic [DEPTH_LOG2:0] r_words;
    logic [DEPTH_LOG2:0] w_wptr_inc;
    logic                r_ovf;
    logic                w_start;
    logic                w_accept;
    logic                w_full;
    logic                w_wr;
    logic                w_oor;
    logic                w_unused;
    InstBus              w_word;
    InstBus              r_mem [2**DEPTH_LOG2];

    assign w_start    = (r_state == LD_IDLE) & bus.ld_start;
    assign w_accept   = (r_state == LD_LOAD) & bus.ld_valid;
    // pointer saturates at 2^DEPTH_LOG2; its top bit marks a full array
    assign w_full     = r_wptr[DEPTH_LOG2];
    assign w_wptr_inc = r_wptr + {{DEPTH_LOG2{1'b0}}, 1'b1};

    ld_word_pack u_pack (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clr        (w_start),
        .i_en         (w_accept & ~w_full),
        .i_byte       (bus.ld_byte),
        .i_last       (bus.ld_last),
        .o_word_valid (w_wr),
        .o_word       (w_word)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            LD_IDLE: w_next = bus.ld_start ? LD_LOAD : LD_IDLE;
            LD_LOAD: w_next = (w_accept & bus.ld_last) ? LD_DONE : LD_LOAD;
            default: w_next = LD_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= LD_IDLE;
            r_wptr  <= '0;
            r_words <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_wptr <= '0;
                r_ovf  <= 1'b0;
            end else begin
                if (w_wr) r_wptr <= w_wptr_inc;
                if (w_accept & w_full) r_ovf <= 1'b1;
                // capture the count including a write made by the final byte
                if (w_accept & bus.ld_last) r_words <= w_wr ? w_wptr_inc : r_wptr;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= w_word;
    end

    assign bus.ld_ready = (r_state == LD_LOAD);
    assign bus.ld_done  = (r_state == LD_DONE);
    assign bus.cpu_hold = (r_state != LD_IDLE);
    assign bus.ld_words = r_words;
    assign bus.ld_ovf   = r_ovf;

    assign w_oor        = |bus.addr[31:DEPTH_LOG2+2];
    assign bus.addr_err = (bus.ce == ChipEnable) & w_oor;
    assign bus.inst     = (bus.ce == ChipDisable || bus.cpu_hold || w_oor)
                          ? ZeroWord : r_mem[bus.addr[DEPTH_LOG2+1:2]];
    assign w_unused     = &{1'b0, bus.addr[1:0]};
endmodule

// File: tb/tb_inst_rom_loader.sv
// tb_inst_rom_loader: scoreboard bench for inst_rom_loader (DEPTH_LOG2 = 10 and 2)
module tb_inst_rom_loader;
    typedef struct {
        logic [31:0] words;
        logic        ovf;
    } done_t;
    typedef struct {
        logic [31:0] inst;
        logic        err;
    } fetch_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        ce = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = 8'h0;
    logic        ld_last = 1'b0;
    int          passed = 0;
    int          total = 0;
    done_t       done_q[$];
    fetch_t      fetch_q[$];
    logic [7:0]  bytes[$];

    always #5 clk = ~clk;

    inst_rom_loader_if #(.DEPTH_LOG2(10)) if10 ();
    inst_rom_loader_if #(.DEPTH_LOG2(2))  if2 ();

    assign if10.ce       = ~sel & ce;
    assign if10.addr     = addr;
    assign if10.ld_start = ~sel & ld_start;
    assign if10.ld_valid = ~sel & ld_valid;
    assign if10.ld_byte  = ld_byte;
    assign if10.ld_last  = ld_last;
    assign if2.ce        = sel & ce;
    assign if2.addr      = addr;
    assign if2.ld_start  = sel & ld_start;
    assign if2.ld_valid  = sel & ld_valid;
    assign if2.ld_byte   = ld_byte;
    assign if2.ld_last   = ld_last;

    wire w_ready = sel ? if2.ld_ready : if10.ld_ready;
    wire w_hold  = sel ? if2.cpu_hold : if10.cpu_hold;

    inst_rom_loader #(.DEPTH_LOG2(10)) u10 (.i_clk(clk), .i_rst_n(rst_n), .bus(if10));
    inst_rom_loader #(.DEPTH_LOG2(2))  u2  (.i_clk(clk), .i_rst_n(rst_n), .bus(if2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    // monitor: pops an expectation whenever a DUT completes a session or is fetched
    always @(negedge clk) begin
        done_t  d;
        fetch_t f;
        if (if10.ld_done || if2.ld_done) begin
            if (done_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                d = done_q.pop_front();
                chk("ld_words", if10.ld_done ? 32'(if10.ld_words) : 32'(if2.ld_words), d.words);
                chk("ld_ovf", if10.ld_done ? 32'(if10.ld_ovf) : 32'(if2.ld_ovf), 32'(d.ovf));
            end
        end
        if (if10.ce || if2.ce) begin
            if (fetch_q.size() == 0) chk("unexpected_fetch", 1, 0);
            else begin
                f = fetch_q.pop_front();
                chk("inst", if10.ce ? if10.inst : if2.inst, f.inst);
                chk("addr_err", if10.ce ? 32'(if10.addr_err) : 32'(if2.addr_err), 32'(f.err));
            end
        end
    end

    task automatic fetch(input logic s, input logic [31:0] a, input logic [31:0] ei, input logic ee);
        fetch_q.push_back('{inst: ei, err: ee});
        sel = s;
        addr = a;
        ce = 1'b1;
        @(posedge clk); #1;
        ce = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input logic rnd);
        int k;
        if (rnd) repeat ($urandom_range(0, 2)) begin
            ld_valid = 1'b0;
            ld_last = 1'b1;
            ld_byte = ~b;
            @(posedge clk); #1;
        end
        ld_valid = 1'b1;
        ld_byte = b;
        ld_last = last;
        for (k = 0; k < 20 && !w_ready; k++) begin
            @(posedge clk); #1;
        end
        if (!w_ready) chk("ready_timeout", 0, 1);
        else begin
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        ld_last = 1'b0;
    endtask

    task automatic load(input logic s, input logic rnd, input logic do_last,
                        input logic [31:0] ew, input logic eo);
        if (do_last) done_q.push_back('{words: ew, ovf: eo});
        sel = s;
        ld_start = 1'b1;
        @(posedge clk); #1;
        ld_start = 1'b0;
        chk("hold_after_start", 32'(w_hold), 1);
        fetch(s, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < bytes.size(); i++)
            send_byte(bytes[i], do_last && (i == bytes.size() - 1), rnd);
        if (do_last) begin
            chk("hold_in_done", 32'(w_hold), 1);
            @(posedge clk); #1;
            chk("hold_after_done", 32'(w_hold), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2;
        chk("reset_outs10", {if10.ld_ready, if10.ld_done, 21'(if10.ld_words), if10.ld_ovf, if10.cpu_hold}, 0);
        chk("reset_outs2", {if2.ld_ready, if2.ld_done, 3'(if2.ld_words), if2.ld_ovf, if2.cpu_hold}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        bytes = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        load(1'b0, 1'b0, 1'b1, 2, 1'b0);
        fetch(1'b0, 32'h0, 32'h0102_0304, 1'b0);
        fetch(1'b0, 32'h4, 32'h0506_0708, 1'b0);

        bytes = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        load(1'b0, 1'b1, 1'b1, 2, 1'b0);
        fetch(1'b0, 32'h0, 32'hAABB_CCDD, 1'b0);
        fetch(1'b0, 32'h7, 32'hEEFF_0000, 1'b0);

        fetch(1'b0, 32'h0000_1000, 32'h0, 1'b1);
        fetch(1'b0, 32'h8000_0004, 32'h0, 1'b1);
        sel = 1'b0;
        addr = 32'h0000_1000;
        ce = 1'b0;
        #1;
        chk("addr_err_ce0", 32'(if10.addr_err), 0);
        chk("inst_ce0", if10.inst, 0);

        bytes.delete();
        for (int i = 0; i < 20; i++) bytes.push_back(8'(8'h10 + i));
        load(1'b1, 1'b0, 1'b1, 4, 1'b1);
        fetch(1'b1, 32'h0, 32'h1011_1213, 1'b0);
        fetch(1'b1, 32'h4, 32'h1415_1617, 1'b0);
        fetch(1'b1, 32'h8, 32'h1819_1A1B, 1'b0);
        fetch(1'b1, 32'hC, 32'h1C1D_1E1F, 1'b0);
        fetch(1'b1, 32'h10, 32'h0, 1'b1);

        bytes = {8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
        load(1'b0, 1'b0, 1'b0, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("reset_in_load", {if10.ld_ready, if10.ld_done, 21'(if10.ld_words), if10.ld_ovf, if10.cpu_hold}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fetch(1'b0, 32'h0, 32'h5152_5354, 1'b0);
        fetch(1'b0, 32'h4, 32'hEEFF_0000, 1'b0);

        bytes = {8'h61, 8'h62, 8'h63, 8'h64};
        load(1'b0, 1'b0, 1'b1, 1, 1'b0);
        fetch(1'b0, 32'h0, 32'h6162_6364, 1'b0);
        fetch(1'b0, 32'h4, 32'hEEFF_0000, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("done_q_empty", 32'(done_q.size()), 0);
        chk("fetch_q_empty", 32'(fetch_q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
